note_tracker: RTL and testbench

- Consumes the 3-bit game `mode` from the state FSM and runs the song timeline during RUN.
- Generates the beat timing and steps through the note index that addresses the external song ROM.
- Judges player lane presses against each note and keeps score and combo.
- Raises `song_done` so the FSM can autofinish at the end of the song.

---
 rtl/note_tracker.sv | 141 ++++++++++++++
 tb/tb_note_tracker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tracker.sv
// -----------------------------------------------------------------------------
// note_tracker
//   Runs the song timeline while the game is in RUN: counts clock ticks per
//   beat, steps the note index that addresses the external song ROM, judges
//   lane presses collected during each beat against that note's lane mask,
//   and keeps score and combo. song_done tells the game FSM the song is over.
//
// Parameters
//   BEAT_TICKS   clock cycles per beat at difficulty 0 (>= 8)
//   NUM_NOTES    notes per song (1..63)
//
// Ports
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   mode          game mode (IDLE=1 EDIT=2 DIFF=3 RUN=4 PAUSE=5 FINISH=6,
//                 any other code behaves as IDLE)
//   diff_level    difficulty select, captured only while mode==DIFF
//   hit_pulse     one-cycle lane press pulses (already synchronised)
//   note_pattern  expected lane mask of note note_count (0 = rest)
//   note_count    current note index / ROM address
//   beat          one-cycle pulse on the judging cycle
//   hit_flag      one-cycle pulse, cycle after beat: note hit
//   miss_flag     one-cycle pulse, cycle after beat: note missed
//   score         number of hits, saturating at 1023
//   combo         consecutive hits, saturating at 63
//   song_done     level, high once every note has been judged
// -----------------------------------------------------------------------------
module note_tracker #(
  parameter logic [23:0] BEAT_TICKS = 24'd6000000,
  parameter logic [5:0]  NUM_NOTES  = 6'd42
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [2:0]  mode,
  input  logic [1:0]  diff_level,
  input  logic [3:0]  hit_pulse,
  input  logic [3:0]  note_pattern,
  output logic [5:0]  note_count,
  output logic        beat,
  output logic        hit_flag,
  output logic        miss_flag,
  output logic [9:0]  score,
  output logic [5:0]  combo,
  output logic        song_done
);

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd1,
    MODE_EDIT   = 3'd2,
    MODE_DIFF   = 3'd3,
    MODE_RUN    = 3'd4,
    MODE_PAUSE  = 3'd5,
    MODE_FINISH = 3'd6
  } mode_e;

  mode_e       mode_s;
  logic [1:0]  diff_lvl_q;
  logic [23:0] tick_cnt;
  logic [3:0]  capture;
  logic [23:0] beat_len;
  logic        beat_end;
  logic        run_active;
  logic [3:0]  judge;

  assign mode_s     = mode_e'(mode);
  assign beat_len   = BEAT_TICKS >> diff_lvl_q;
  // ">=" rather than "==" so that a tick count left over from a longer beat
  // (difficulty raised mid-song) still terminates the beat immediately.
  assign beat_end   = (tick_cnt >= (beat_len - 24'd1));
  assign run_active = (mode_s == MODE_RUN) && !song_done;
  assign beat       = run_active && beat_end;
  // A press landing on the judging cycle itself still counts for this note.
  assign judge      = capture | hit_pulse;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      diff_lvl_q <= 2'd0;
      tick_cnt   <= 24'd0;
      capture    <= 4'd0;
      note_count <= 6'd0;
      score      <= 10'd0;
      combo      <= 6'd0;
      song_done  <= 1'b0;
      hit_flag   <= 1'b0;
      miss_flag  <= 1'b0;
    end else begin
      hit_flag  <= 1'b0;
      miss_flag <= 1'b0;

      if (mode_s == MODE_DIFF) begin
        diff_lvl_q <= diff_level;
      end

      case (mode_s)
        MODE_RUN: begin
          if (!song_done) begin
            if (beat_end) begin
              tick_cnt <= 24'd0;
              capture  <= 4'd0;

              if (note_pattern != 4'd0) begin
                if (judge == note_pattern) begin
                  hit_flag <= 1'b1;
                  if (score != 10'h3ff) score <= score + 10'd1;
                  if (combo != 6'h3f)   combo <= combo + 6'd1;
                end else begin
                  miss_flag <= 1'b1;
                  combo     <= 6'd0;
                end
              end

              if (note_count == NUM_NOTES - 6'd1) begin
                song_done <= 1'b1;
              end else begin
                note_count <= note_count + 6'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 24'd1;
              capture  <= capture | hit_pulse;
            end
          end
        end

        MODE_EDIT, MODE_DIFF, MODE_PAUSE, MODE_FINISH: begin
          // Game state holds; PAUSE drops any presses.
        end

        default: begin
          // IDLE and unused codes start a fresh song; difficulty is kept.
          tick_cnt   <= 24'd0;
          capture    <= 4'd0;
          note_count <= 6'd0;
          score      <= 10'd0;
          combo      <= 6'd0;
          song_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tracker.sv
// -----------------------------------------------------------------------------
// tb_note_tracker
//   Bench for note_tracker. Two instances share every input:
//     u_dut  : BEAT_TICKS=16, NUM_NOTES=42 (beat length 4/8/16 via difficulty)
//     u_dut5 : BEAT_TICKS=8,  NUM_NOTES=3  (end-of-song behaviour)
//   Expected judgements are pushed into a queue from a small model when a
//   beat's stimulus is driven and popped when the flags appear.
// -----------------------------------------------------------------------------
module tb_note_tracker;

  localparam logic [2:0] M_IDLE = 3'd1, M_EDIT = 3'd2, M_DIFF = 3'd3,
                         M_RUN = 3'd4, M_PAUSE = 3'd5, M_FINISH = 3'd6;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] mode;
  logic [1:0] diff_level;
  logic [3:0] hit_pulse;
  logic [3:0] note_pattern;

  logic [5:0] note_count, note_count5;
  logic       beat, beat5, hit_flag, hit_flag5, miss_flag, miss_flag5;
  logic [9:0] score, score5;
  logic [5:0] combo, combo5;
  logic       song_done, song_done5;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [9:0] score;
    logic [5:0] combo;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp5_q[$];
  exp_t got_a, got_b, e;
  int   m_score, m_combo, m5_score, m5_combo;
  int   checks = 0;
  int   passed = 0;
  int   ba, bb;

  assign got_a = {hit_flag, miss_flag, score, combo};
  assign got_b = {hit_flag5, miss_flag5, score5, combo5};

  always #5 clk = ~clk;

  note_tracker #(.BEAT_TICKS(24'd16), .NUM_NOTES(6'd42)) u_dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .diff_level(diff_level),
    .hit_pulse(hit_pulse), .note_pattern(note_pattern),
    .note_count(note_count), .beat(beat), .hit_flag(hit_flag),
    .miss_flag(miss_flag), .score(score), .combo(combo), .song_done(song_done)
  );

  note_tracker #(.BEAT_TICKS(24'd8), .NUM_NOTES(6'd3)) u_dut5 (
    .clk(clk), .n_rst(n_rst), .mode(mode), .diff_level(diff_level),
    .hit_pulse(hit_pulse), .note_pattern(note_pattern),
    .note_count(note_count5), .beat(beat5), .hit_flag(hit_flag5),
    .miss_flag(miss_flag5), .score(score5), .combo(combo5), .song_done(song_done5)
  );

  // Reference judgement: sel=0 models u_dut, sel=1 models u_dut5.
  task automatic model_push(input bit sel, input logic [3:0] pat, input logic [3:0] j);
    exp_t x;
    int s, c;
    s = sel ? m5_score : m_score;
    c = sel ? m5_combo : m_combo;
    x.hit = 1'b0;
    x.miss = 1'b0;
    if (pat != 4'd0) begin
      if (j == pat) begin
        x.hit = 1'b1;
        if (s < 1023) s++;
        if (c < 63) c++;
      end else begin
        x.miss = 1'b1;
        c = 0;
      end
    end
    x.score = s[9:0];
    x.combo = c[5:0];
    if (sel) begin m5_score = s; m5_combo = c; exp5_q.push_back(x); end
    else     begin m_score = s;  m_combo = c;  exp_q.push_back(x);  end
  endtask

  // Called at posedge+1. Drives len RUN cycles with up to two press events and
  // returns the first cycle index at which each instance raised beat (-1: none).
  task automatic drive_beat(input int len, input logic [3:0] pat,
                            input int ta, input logic [3:0] ma,
                            input int tb, input logic [3:0] mb,
                            output int beat_at, output int beat5_at);
    mode = M_RUN;
    note_pattern = pat;
    beat_at = -1;
    beat5_at = -1;
    for (int k = 0; k < len; k++) begin
      hit_pulse = ((k == ta) ? ma : 4'd0) | ((k == tb) ? mb : 4'd0);
      #1;
      if (beat && beat_at < 0) beat_at = k;
      if (beat5 && beat5_at < 0) beat5_at = k;
      @(posedge clk); #1;
    end
    hit_pulse = 4'd0;
  endtask

  task automatic tick(input logic [2:0] m);
    mode = m;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; mode = M_IDLE; diff_level = 2'd0;
    hit_pulse = 4'd0; note_pattern = 4'd0;
    m_score = 0; m_combo = 0; m5_score = 0; m5_combo = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({note_count, score, combo, song_done, beat, hit_flag, miss_flag} !== 25'd0)
      $display("FAIL reset_outputs: got nc=%0d sc=%0d co=%0d done=%0b beat=%0b hit=%0b miss=%0b, want all 0",
               note_count, score, combo, song_done, beat, hit_flag, miss_flag);
    else passed++;
    checks++; if ({note_count5, score5, song_done5} !== 17'd0)
      $display("FAIL reset_outputs5: got nc=%0d sc=%0d done=%0b, want 0", note_count5, score5, song_done5);
    else passed++;
    $display("reset: n_rst held low 2 cycles");
    n_rst = 1'b1;
  endtask

  task automatic test_first_beat;
    diff_level = 2'd2;
    tick(M_DIFF);
    diff_level = 2'd0;  // ignored outside DIFF
    checks++; if (note_count !== 6'd0)
      $display("FAIL first_nc_before: got %0d, want 0", note_count);
    else passed++;
    model_push(1'b0, 4'd0, 4'd0);
    drive_beat(4, 4'd0, -1, 4'd0, -1, 4'd0, ba, bb);
    $display("first_beat: beat_at=%0d beat5_at=%0d note_count=%0d", ba, bb, note_count);
    checks++; if (ba !== 3) $display("FAIL first_beat_latency: got %0d, want 3", ba); else passed++;
    checks++; if (bb !== 1) $display("FAIL first_beat5_latency: got %0d, want 1", bb); else passed++;
    checks++; if (note_count !== 6'd1) $display("FAIL first_nc_after: got %0d, want 1", note_count); else passed++;
    e = exp_q.pop_front();
    checks++; if (got_a !== e)
      $display("FAIL first_rest_judge: got hit=%0b miss=%0b sc=%0d co=%0d, want hit=%0b miss=%0b sc=%0d co=%0d",
               got_a.hit, got_a.miss, got_a.score, got_a.combo, e.hit, e.miss, e.score, e.combo);
    else passed++;
  endtask

  task automatic test_hit;
    tick(M_IDLE);
    diff_level = 2'd1;  // 16 >> 1 = 8
    tick(M_DIFF);
    model_push(1'b0, 4'b0101, 4'b0101);
    drive_beat(8, 4'b0101, 2, 4'b0001, 7, 4'b0100, ba, bb);
    e = exp_q.pop_front();
    $display("hit: beat_at=%0d hit=%0b miss=%0b score=%0d combo=%0d", ba, hit_flag, miss_flag, score, combo);
    checks++; if (ba !== 7) $display("FAIL hit_beat_pos: got %0d, want 7", ba); else passed++;
    checks++; if (got_a !== e)
      $display("FAIL hit_judge: got hit=%0b miss=%0b sc=%0d co=%0d, want hit=%0b miss=%0b sc=%0d co=%0d",
               got_a.hit, got_a.miss, got_a.score, got_a.combo, e.hit, e.miss, e.score, e.combo);
    else passed++;
    tick(M_EDIT);
    checks++; if ({hit_flag, miss_flag, score} !== {2'b00, 10'd1})
      $display("FAIL hit_pulse_width: got hit=%0b miss=%0b sc=%0d, want 0 0 1", hit_flag, miss_flag, score);
    else passed++;
  endtask

  task automatic test_miss_and_rest;
    logic [3:0] pat_t [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0011};
    logic [3:0] msk_t [5] = '{4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      model_push(1'b0, pat_t[i], msk_t[i]);
      drive_beat(8, pat_t[i], 7, msk_t[i], -1, 4'd0, ba, bb);
      e = exp_q.pop_front();
      $display("judge[%0d]: pat=%b press=%b hit=%0b miss=%0b score=%0d combo=%0d",
               i, pat_t[i], msk_t[i], hit_flag, miss_flag, score, combo);
      checks++; if (ba !== 7) $display("FAIL judge_beat_pos[%0d]: got %0d, want 7", i, ba); else passed++;
      checks++; if (got_a !== e)
        $display("FAIL judge[%0d]: got hit=%0b miss=%0b sc=%0d co=%0d, want hit=%0b miss=%0b sc=%0d co=%0d",
                 i, got_a.hit, got_a.miss, got_a.score, got_a.combo, e.hit, e.miss, e.score, e.combo);
      else passed++;
    end
  endtask

  task automatic test_pause;
    int pause_beats;
    drive_beat(3, 4'b1111, -1, 4'd0, -1, 4'd0, ba, bb);
    checks++; if (ba !== -1) $display("FAIL pause_pre_beat: got %0d, want -1", ba); else passed++;
    pause_beats = 0;
    hit_pulse = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      mode = M_PAUSE;
      #1;
      if (beat) pause_beats++;
      @(posedge clk); #1;
    end
    hit_pulse = 4'd0;
    checks++; if (pause_beats !== 0) $display("FAIL pause_no_beat: got %0d beats, want 0", pause_beats); else passed++;
    model_push(1'b0, 4'b1111, 4'b0000);
    drive_beat(5, 4'b1111, -1, 4'd0, -1, 4'd0, ba, bb);
    e = exp_q.pop_front();
    $display("pause: resume beat_at=%0d hit=%0b miss=%0b combo=%0d", ba, hit_flag, miss_flag, combo);
    checks++; if (ba !== 4) $display("FAIL pause_resume_pos: got %0d, want 4", ba); else passed++;
    checks++; if (got_a !== e)
      $display("FAIL pause_judge: got hit=%0b miss=%0b sc=%0d co=%0d, want hit=%0b miss=%0b sc=%0d co=%0d",
               got_a.hit, got_a.miss, got_a.score, got_a.combo, e.hit, e.miss, e.score, e.combo);
    else passed++;
  endtask

  task automatic test_song_end;
    tick(M_IDLE);
    diff_level = 2'd0;  // u_dut5 beat length 8
    tick(M_DIFF);
    m5_score = 0; m5_combo = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (song_done5 !== 1'b0) $display("FAIL end_done_early[%0d]: got 1, want 0", i); else passed++;
      model_push(1'b1, 4'b1111, 4'b1111);
      drive_beat(8, 4'b1111, 7, 4'b1111, -1, 4'd0, ba, bb);
      e = exp5_q.pop_front();
      $display("song_end[%0d]: beat5_at=%0d hit=%0b score=%0d nc=%0d done=%0b",
               i, bb, hit_flag5, score5, note_count5, song_done5);
      checks++; if (bb !== 7) $display("FAIL end_beat_pos[%0d]: got %0d, want 7", i, bb); else passed++;
      checks++; if (got_b !== e)
        $display("FAIL end_judge[%0d]: got hit=%0b miss=%0b sc=%0d co=%0d, want hit=%0b miss=%0b sc=%0d co=%0d",
                 i, got_b.hit, got_b.miss, got_b.score, got_b.combo, e.hit, e.miss, e.score, e.combo);
      else passed++;
    end
    checks++; if ({song_done5, note_count5} !== {1'b1, 6'd2})
      $display("FAIL end_done: got done=%0b nc=%0d, want 1 2", song_done5, note_count5);
    else passed++;
    drive_beat(20, 4'b1111, 3, 4'b1111, -1, 4'd0, ba, bb);
    checks++; if (bb !== -1) $display("FAIL end_no_beat: got beat at %0d, want none", bb); else passed++;
    checks++; if ({note_count5, score5} !== {6'd2, 10'd3})
      $display("FAIL end_hold: got nc=%0d sc=%0d, want 2 3", note_count5, score5);
    else passed++;
    repeat (3) tick(M_FINISH);
    checks++; if ({score5, combo5, song_done5} !== {10'd3, 6'd3, 1'b1})
      $display("FAIL finish_hold: got sc=%0d co=%0d done=%0b, want 3 3 1", score5, combo5, song_done5);
    else passed++;
    tick(M_IDLE);
    $display("song_end: after IDLE score5=%0d nc5=%0d done5=%0b", score5, note_count5, song_done5);
    checks++; if ({score5, combo5, note_count5, song_done5} !== 23'd0)
      $display("FAIL idle_clear: got sc=%0d co=%0d nc=%0d done=%0b, want 0",
               score5, combo5, note_count5, song_done5);
    else passed++;
  endtask

  task automatic test_async_reset;
    tick(M_IDLE);
    diff_level = 2'd1;
    tick(M_DIFF);
    m_score = 0; m_combo = 0;
    for (int i = 0; i < 5; i++) begin
      model_push(1'b0, 4'b0010, 4'b0010);
      drive_beat(8, 4'b0010, 3, 4'b0010, -1, 4'd0, ba, bb);
      e = exp_q.pop_front();
    end
    checks++; if (got_a !== e)
      $display("FAIL rst_pre_score: got sc=%0d co=%0d, want sc=%0d co=%0d", score, combo, e.score, e.combo);
    else passed++;
    drive_beat(3, 4'b0010, -1, 4'd0, -1, 4'd0, ba, bb);
    #2;
    n_rst = 1'b0;
    #1;
    $display("async_reset: mid-beat, score=%0d nc=%0d beat=%0b", score, note_count, beat);
    checks++; if ({note_count, score, combo, song_done, beat, hit_flag, miss_flag} !== 25'd0)
      $display("FAIL rst_immediate: got nc=%0d sc=%0d co=%0d done=%0b beat=%0b, want all 0",
               note_count, score, combo, song_done, beat);
    else passed++;
    mode = M_IDLE;
    #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    m_score = 0; m_combo = 0;
    model_push(1'b0, 4'b0101, 4'b0101);
    drive_beat(16, 4'b0101, 15, 4'b0101, -1, 4'd0, ba, bb);
    e = exp_q.pop_front();
    $display("async_reset: restart beat_at=%0d beat5_at=%0d score=%0d", ba, bb, score);
    checks++; if (ba !== 15) $display("FAIL rst_restart_pos: got %0d, want 15", ba); else passed++;
    checks++; if (bb !== 7) $display("FAIL rst_restart5_pos: got %0d, want 7", bb); else passed++;
    checks++; if (got_a !== e)
      $display("FAIL rst_restart_judge: got hit=%0b sc=%0d co=%0d, want hit=%0b sc=%0d co=%0d",
               got_a.hit, got_a.score, got_a.combo, e.hit, e.score, e.combo);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_first_beat;
    test_hit;
    test_miss_and_rest;
    test_pause;
    test_song_end;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end

endmodule
